// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory unit between the instruction-fetch
// port (I, read-only word) and the load/store port (D).
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   i_req/i_addr          fetch request, held until i_ack
//   i_ack/i_rdata/i_fault one-cycle fetch completion, data, fault qualifier
//   d_req/d_we/d_funct3/
//   d_addr/d_wdata        load/store request, held until d_ack
//   d_ack/d_rdata/d_fault one-cycle load/store completion, data, fault
//   mem_*                 memory handshake (mem_ce active low)
//   timeout               one-cycle pulse when the watchdog forces completion
//
// Flow: IDLE grants one port (round-robin on ties), BUSY holds the memory
// request until the memory reports completion (or the watchdog fires), and
// RELEASE keeps mem_ce high for one cycle so the memory returns to idle.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576  // 0 disables the watchdog
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  output logic        mem_ce,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_memwrite,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic        mem_fault,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  // Port encoding for owner/last_grant: 0 = I, 1 = D.
  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        seen_q, seen_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ce_q, ce_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        we_q, we_d;
  logic        i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        i_fault_q, i_fault_d, d_fault_q, d_fault_d;
  logic        timeout_q, timeout_d;

  logic        done;
  logic        wd_fire;
  logic        grant_d;

  // Writes and register accesses never raise valid; they finish when busy
  // drops after having been seen high.
  assign done    = mem_fault | mem_valid | (seen_q & ~mem_busy);
  assign wd_fire = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == TIMEOUT_CYCLES - 32'd1);
  // D wins when alone, or on a tie when I was served last.
  assign grant_d = d_req & (~i_req | ~last_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;
    ce_d      = ce_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = we_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    timeout_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_fault_d = i_fault_q;
    d_fault_d = d_fault_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          owner_d = grant_d;
          last_d  = grant_d;
          seen_d  = 1'b0;
          cnt_d   = 32'd0;
          ce_d    = 1'b0;
          state_d = BUSY;
          if (grant_d) begin
            addr_d = d_addr;
            f3_d   = d_funct3;
            we_d   = d_we;
            din_d  = d_wdata;
          end else begin
            addr_d = i_addr;
            f3_d   = 3'b010;
            we_d   = 1'b0;
            din_d  = 32'd0;
          end
        end
      end
      BUSY: begin
        if (mem_busy) seen_d = 1'b1;
        if (done) begin
          ce_d    = 1'b1;
          state_d = RELEASE;
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_fault_d = mem_fault;
            if (!we_q && !mem_fault) d_rdata_d = mem_dataout;
          end else begin
            i_ack_d   = 1'b1;
            i_fault_d = mem_fault;
            if (!mem_fault) i_rdata_d = mem_dataout;
          end
        end else if (wd_fire) begin
          ce_d      = 1'b1;
          timeout_d = 1'b1;
          state_d   = RELEASE;
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_fault_d = 1'b1;
          end else begin
            i_ack_d   = 1'b1;
            i_fault_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      seen_q    <= 1'b0;
      cnt_q     <= 32'd0;
      ce_q      <= 1'b1;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      din_q     <= 32'd0;
      we_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_fault_q <= 1'b0;
      d_fault_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_fault_q <= i_fault_d;
      d_fault_q <= d_fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign i_ack        = i_ack_q;
  assign i_rdata      = i_rdata_q;
  assign i_fault      = i_fault_q;
  assign d_ack        = d_ack_q;
  assign d_rdata      = d_rdata_q;
  assign d_fault      = d_fault_q;
  assign mem_ce       = ce_q;
  assign mem_funct3   = f3_q;
  assign mem_addr     = addr_q;
  assign mem_datain   = din_q;
  assign mem_memwrite = we_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural memory model answers
// the ce handshake in one of several modes; a second instance with a short
// watchdog observes the hang scenario.
module tb_mem_port_arbiter;
  logic        clk, reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] mem_dataout;
  logic        mem_busy, mem_valid, mem_fault;

  logic        i_ack, i_fault, d_ack, d_fault, mem_ce, mem_memwrite, timeout;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_datain;
  logic [2:0]  mem_funct3;

  logic        w_i_ack, w_i_fault, w_d_ack, w_d_fault, w_mem_ce, w_mem_memwrite, w_timeout;
  logic [31:0] w_i_rdata, w_d_rdata, w_mem_addr, w_mem_datain;
  logic [2:0]  w_mem_funct3;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model controls: 0 read (valid after lat), 1 store (busy 1 cycle),
  // 2 fault one cycle after ce low, 3 busy forever, 4 read tagged by address.
  int          mode = 0;
  int          lat  = 3;
  logic [31:0] rd_val = 32'd0;
  int          mcnt;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_fault(i_fault),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_fault(d_fault),
    .mem_ce(mem_ce), .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_memwrite(mem_memwrite), .mem_dataout(mem_dataout), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_fault(mem_fault), .timeout(timeout)
  );

  mem_port_arbiter #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(w_i_ack), .i_rdata(w_i_rdata), .i_fault(w_i_fault),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(w_d_ack), .d_rdata(w_d_rdata), .d_fault(w_d_fault),
    .mem_ce(w_mem_ce), .mem_funct3(w_mem_funct3), .mem_addr(w_mem_addr), .mem_datain(w_mem_datain),
    .mem_memwrite(w_mem_memwrite), .mem_dataout(mem_dataout), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_fault(mem_fault), .timeout(w_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model, keyed off the main instance's chip enable.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt <= 0; mem_busy <= 1'b0; mem_valid <= 1'b0; mem_fault <= 1'b0; mem_dataout <= 32'd0;
    end else if (!mem_ce) begin
      mcnt <= mcnt + 1; mem_busy <= 1'b0; mem_valid <= 1'b0; mem_fault <= 1'b0;
      case (mode)
        0: if (mcnt == lat - 1) begin mem_valid <= 1'b1; mem_dataout <= rd_val; end
        1: mem_busy <= (mcnt == 0);
        2: if (mcnt == 0) begin mem_fault <= 1'b1; mem_dataout <= rd_val; end
        3: mem_busy <= 1'b1;
        4: if (mcnt == lat - 1) begin mem_valid <= 1'b1; mem_dataout <= {16'hC0DE, mem_addr[15:0]}; end
        default: ;
      endcase
    end else begin
      mcnt <= 0; mem_busy <= 1'b0; mem_valid <= 1'b0; mem_fault <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycles from the current negedge until an ack is seen (bounded).
  task automatic wait_ack(input bit wd, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      n++;
      if (wd ? (w_i_ack | w_d_ack) : (i_ack | d_ack)) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  exp_d;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_funct3 = 3'd0;
    @(negedge clk);
    chk("rst_ce", {31'd0, mem_ce}, 32'd1);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_misc", {27'd0, mem_funct3, mem_memwrite, timeout}, 32'd0);
    reset = 1'b1;
    step();

    // I-only read, data after 20 cycles
    i_req = 1'b1; i_addr = 32'h100; mode = 0; lat = 20; rd_val = 32'hDEADBEEF;
    step();
    chk("t1_ce_low", {31'd0, mem_ce}, 32'd0);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_f3_we", {28'd0, mem_funct3, mem_memwrite}, {28'd0, 3'b010, 1'b0});
    wait_ack(1'b0, n);
    chk("t1_lat", 32'(n), 32'd21);
    chk("t1_acks", {30'd0, i_ack, d_ack}, 32'd2);
    chk("t1_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_fault", {31'd0, i_fault}, 32'd0);
    chk("t1_ce_rel", {31'd0, mem_ce}, 32'd1);
    i_req = 1'b0;
    step();
    chk("t1_ack_pulse", {30'd0, i_ack, d_ack}, 32'd0);
    chk("t1_ce_idle", {31'd0, mem_ce}, 32'd1);
    step();

    // D store to GPIO
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0080_0000; d_wdata = 32'hA5; d_funct3 = 3'b010; mode = 1;
    step();
    chk("t2_ce_low", {31'd0, mem_ce}, 32'd0);
    chk("t2_we", {31'd0, mem_memwrite}, 32'd1);
    chk("t2_datain", mem_datain, 32'hA5);
    chk("t2_addr", mem_addr, 32'h0080_0000);
    wait_ack(1'b0, n);
    chk("t2_lat", 32'(n), 32'd3);
    chk("t2_acks", {30'd0, i_ack, d_ack}, 32'd1);
    chk("t2_fault", {31'd0, d_fault}, 32'd0);
    chk("t2_rdata_kept", d_rdata, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    step();

    // Simultaneous requests from reset: D, I, D
    reset = 1'b0;
    step();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_funct3 = 3'b100;
    mode = 4; lat = 3;
    for (int g = 0; g < 3; g++) begin
      exp_d = (g != 1);
      step();
      chk($sformatf("t3_g%0d_ce", g), {31'd0, mem_ce}, 32'd0);
      chk($sformatf("t3_g%0d_addr", g), mem_addr, exp_d ? 32'h300 : 32'h200);
      chk($sformatf("t3_g%0d_f3", g), {29'd0, mem_funct3}, exp_d ? 32'd4 : 32'd2);
      wait_ack(1'b0, n);
      chk($sformatf("t3_g%0d_lat", g), 32'(n), 32'd4);
      chk($sformatf("t3_g%0d_acks", g), {30'd0, i_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
      chk($sformatf("t3_g%0d_rdata", g), exp_d ? d_rdata : i_rdata,
          exp_d ? 32'hC0DE0300 : 32'hC0DE0200);
      if (g == 2) begin i_req = 1'b0; d_req = 1'b0; end
      step();
      chk($sformatf("t3_g%0d_rel", g), {30'd0, mem_ce, i_ack | d_ack}, 32'd2);
    end
    step();

    // Fault on a D load: rdata must stay at its last value
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0090_0000; d_funct3 = 3'b010; mode = 2; rd_val = 32'h12345678;
    step();
    chk("t4_ce_low", {31'd0, mem_ce}, 32'd0);
    wait_ack(1'b0, n);
    chk("t4_lat", 32'(n), 32'd2);
    chk("t4_acks", {30'd0, i_ack, d_ack}, 32'd1);
    chk("t4_fault", {31'd0, d_fault}, 32'd1);
    chk("t4_rdata_kept", d_rdata, 32'hC0DE0300);
    d_req = 1'b0;
    step();
    step();
    chk("t4_idle", {30'd0, mem_ce, d_ack}, 32'd2);

    // Watchdog on the 16-cycle instance; memory busy forever
    reset = 1'b0;
    step();
    reset = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00A0_0000; mode = 3;
    step();
    chk("t5_ce_low", {31'd0, w_mem_ce}, 32'd0);
    wait_ack(1'b1, n);
    chk("t5_lat", 32'(n), 32'd16);
    chk("t5_acks", {30'd0, w_i_ack, w_d_ack}, 32'd1);
    chk("t5_fault_to", {30'd0, w_d_fault, w_timeout}, 32'd3);
    chk("t5_ce_high", {31'd0, w_mem_ce}, 32'd1);
    chk("t5_nowd_busy", {31'd0, mem_ce}, 32'd0);
    d_req = 1'b0;
    step();
    chk("t5_pulse", {30'd0, w_timeout, w_d_ack}, 32'd0);

    // Async reset while the main instance is stuck in BUSY
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_ce_async", {31'd0, mem_ce}, 32'd1);
    chk("t6_acks_async", {29'd0, i_ack, d_ack, timeout}, 32'd0);
    chk("t6_addr_async", mem_addr, 32'd0);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mode = 0; lat = 3; rd_val = 32'h600DF00D;
    step();
    chk("t6_no_grant_in_rst", {31'd0, mem_ce}, 32'd1);
    reset = 1'b1;
    step();
    chk("t6_ce_low", {31'd0, mem_ce}, 32'd0);
    chk("t6_addr", mem_addr, 32'h400);
    wait_ack(1'b0, n);
    chk("t6_lat", 32'(n), 32'd4);
    chk("t6_acks", {30'd0, i_ack, d_ack}, 32'd1);
    chk("t6_rdata", d_rdata, 32'h600DF00D);
    d_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single `memory` unit between two requesters: the instruction-fetch port (I, read-only, word) and the load/store port (D).
- Sequences the active-low `ce` / busy / valid / load_access_fault handshake of `memory`, detects completion and returns one-cycle acks with data or fault.
- Arbitrates round-robin and applies a watchdog timeout so a hung peripheral cannot deadlock the core.
- Sits between the core and `memory` in the top level.

Parameters:
- TIMEOUT_CYCLES, 1048576: maximum cycles in BUSY before a forced fault; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle completion pulse for the fetch
- i_rdata  out  32  fetch data; valid with i_ack, held until the next i_ack
- i_fault  out  1  fault qualifier, valid with i_ack
- d_req  in  1  load/store request; held with d_* fields until d_ack
- d_we  in  1  1 = store
- d_funct3  in  3  access size/sign, passed through
- d_addr  in  32  load/store address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse for load/store
- d_rdata  out  32  load data; valid with d_ack, held until the next d_ack
- d_fault  out  1  fault qualifier, valid with d_ack
- mem_ce  out  1  memory chip enable, active low
- mem_funct3  out  3  to memory funct3
- mem_addr  out  32  to memory addr
- mem_datain  out  32  to memory datain
- mem_memwrite  out  1  to memory memwrite
- mem_dataout  in  32  from memory dataout
- mem_busy  in  1  from memory busy
- mem_valid  in  1  from memory valid
- mem_fault  in  1  from memory load_access_fault
- timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, reset=0):
  - state IDLE, mem_ce=1, mem_memwrite=0, mem_addr/mem_datain=0, mem_funct3=0.
  - All acks, faults, rdata and timeout = 0.
  - last_grant = I, so the first tie goes to D.
- All outputs are registered.
- States: IDLE, BUSY, RELEASE.
- IDLE, cycle T:
  - If exactly one req is high, grant it.
  - If both are high, grant the port not equal to last_grant.
  - On grant:
    - Latch owner.
    - I grant: mem_addr=i_addr, mem_funct3=3'b010, mem_memwrite=0, mem_datain=0.
    - D grant: mem_addr=d_addr, mem_funct3=d_funct3, mem_memwrite=d_we, mem_datain=d_wdata.
    - Set mem_ce=0, clear seen_busy and the watchdog counter, update last_grant, go to BUSY.
    - mem_ce is low from T+1 onward.
- BUSY:
  - mem_* outputs are held constant and mem_ce stays 0.
  - seen_busy <= 1 whenever mem_busy=1.
  - done = mem_fault | mem_valid | (seen_busy & ~mem_busy). This covers:
    - reads via VALID;
    - writes, GPIO and control registers via busy falling to FINISH;
    - faults via FAULT.
  - On done at cycle k:
    - Owner's ack=1 at k+1.
    - Owner's rdata = mem_dataout if the access is a read and not a fault, else rdata unchanged.
    - Owner's fault = mem_fault.
    - mem_ce=1 at k+1, go to RELEASE.
  - Watchdog (TIMEOUT_CYCLES≠0): the counter increments every BUSY cycle without done. When it reaches TIMEOUT_CYCLES-1 and done is still 0:
    - Owner ack with fault=1, timeout=1 for one cycle, mem_ce=1, go to RELEASE.
    - done has priority over timeout in the same cycle.
- RELEASE: exactly one cycle with mem_ce=1 (returns memory to IDLE), acks low, then IDLE. req is not sampled here.
- Throughput:
  - Earliest re-grant is the cycle after RELEASE.
  - Back-to-back requests from one port: grant-to-grant ≥ memory latency + 3 cycles.
- Fault qualifier: fault is only meaningful while ack=1; it is held otherwise.
- Protocol errors (not checked, no recovery):
  - Request fields changing while req=1 before ack have no effect; fields are latched at grant.
  - Dropping req before ack: the access completes and the ack is still produced.
- Never grant while BUSY or RELEASE; at most one ack per cycle; i_ack and d_ack are never both high.
- Reset mid-operation: immediate return to reset values. mem_ce goes high asynchronously, so memory also aborts via its own reset/ce.

Test Plan:
- I-only read: i_req, i_addr=0x100; memory model returns valid with 0xDEADBEEF after 20 cycles.
  - Required: mem_ce low from T+1; i_ack one cycle with i_rdata=0xDEADBEEF, i_fault=0; mem_ce high one cycle; d_ack never high.
- D store to GPIO_OUT 0x00800000, data 0xA5, d_funct3=3'b010; model gives busy 1 cycle, then busy=0/valid=0.
  - Required: mem_memwrite=1, mem_datain=0xA5; d_ack 2 cycles after busy falls-sample; d_fault=0.
- Simultaneous i_req and d_req from reset, both held.
  - Required: grant D first, then I, then D; grants alternate; no overlapping ce-low windows; RELEASE cycle between each pair.
- Fault: d load from 0x00900000; model raises mem_fault one cycle after ce low.
  - Required: d_ack with d_fault=1, d_rdata unchanged from its previous value, arbiter returns to IDLE.
- Watchdog with TIMEOUT_CYCLES=16: model holds busy=1 forever.
  - Required: ack with fault=1 and a timeout pulse exactly 16 cycles after BUSY entry; mem_ce=1 next.
- Async reset asserted mid-BUSY.
  - Required: mem_ce=1, all acks 0 immediately without a clock edge; after release, a pending d_req is granted normally.
